// File: rtl/neuron_pkg.sv
// Shared types and helpers for the time-multiplexed neuron.
`timescale 1ns/1ps
package neuron_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, FINAL, HOLD} state_t;

  function automatic int q_one(input int frac_w);
    return 1 << frac_w;
  endfunction

  // ReLU clamp into a signed data_w-bit range; negative and zero map to 0.
  function automatic logic signed [63:0] sat_to_w(input logic signed [63:0] v,
                                                  input int data_w);
    logic signed [63:0] max_v;
    max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    if (v <= 64'sd0)
      return 64'sd0;
    else if (v > max_v)
      return max_v;
    else
      return v;
  endfunction

endpackage

// File: rtl/neuron_mac.sv
// Registered signed multiply-accumulate with clear, enable and term-enable.
`timescale 1ns/1ps
module neuron_mac #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 35
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic              term_en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    term;
  logic signed [ACC_W-1:0]    acc_d, acc_q;

  // Operands are widened first so the product keeps full precision.
  assign prod = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
  assign term = term_en ? {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod} : '0;

  always_comb begin
    acc_d = acc_q;
    if (clear)
      acc_d = '0;
    else if (en)
      acc_d = acc_q + term;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc_q <= '0;
    else
      acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/neuron_seq.sv
// Sequential neuron: one MAC per clock, bias add, activation, valid/ready output.
// Define NEURON_RELU_EN for saturating ReLU instead of the default step activation.
`timescale 1ns/1ps
module neuron_seq
  import neuron_pkg::*;
#(
  parameter int N_INPUTS = 32,
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int ACC_W    = 2*DATA_W + $clog2(N_INPUTS+1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_INPUTS*DATA_W-1:0] dendrites,
  input  logic [(N_INPUTS+1)*DATA_W-1:0] weights,
  input  logic [N_INPUTS-1:0]        enabled,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          axon
);

  localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int SUM_W = ACC_W + 1;

  state_t                        state_d, state_q;
  logic [N_INPUTS*DATA_W-1:0]    dendrites_d, dendrites_q;
  logic [(N_INPUTS+1)*DATA_W-1:0] weights_d, weights_q;
  logic [N_INPUTS-1:0]           enabled_d, enabled_q;
  logic [IDX_W-1:0]              idx_d, idx_q;
  logic [DATA_W-1:0]             axon_d, axon_q;

  logic                          accept;
  logic [DATA_W-1:0]             cur_dendrite, cur_weight, bias;
  logic                          cur_enable;
  logic [ACC_W-1:0]              acc;
  logic signed [SUM_W-1:0]       acc_ext, bias_ext, sum_pre, sum;
  logic [DATA_W-1:0]             act;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign axon      = axon_q;
  assign accept    = in_ready && in_valid;

  assign cur_dendrite = dendrites_q[int'(idx_q)*DATA_W +: DATA_W];
  assign cur_weight   = weights_q[int'(idx_q)*DATA_W +: DATA_W];
  assign cur_enable   = enabled_q[idx_q];
  assign bias         = weights_q[N_INPUTS*DATA_W +: DATA_W];

  neuron_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .en      (state_q == ACCUM),
    .term_en (cur_enable),
    .a       (cur_dendrite),
    .b       (cur_weight),
    .acc     (acc)
  );

  // Bias is aligned to the product's 2*FRAC_W scale before the floor shift.
  assign acc_ext  = {acc[ACC_W-1], acc};
  assign bias_ext = {{(SUM_W-DATA_W){bias[DATA_W-1]}}, bias} <<< FRAC_W;
  assign sum_pre  = acc_ext + bias_ext;
  assign sum      = sum_pre >>> FRAC_W;

  always_comb begin
    act = '0;
`ifdef NEURON_RELU_EN
    act = DATA_W'(sat_to_w(64'(sum), DATA_W));
`else
    if (sum > 0)
      act = DATA_W'(q_one(FRAC_W));
`endif
  end

  always_comb begin
    state_d     = state_q;
    dendrites_d = dendrites_q;
    weights_d   = weights_q;
    enabled_d   = enabled_q;
    idx_d       = idx_q;
    axon_d      = axon_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          dendrites_d = dendrites;
          weights_d   = weights;
          enabled_d   = enabled;
          idx_d       = '0;
          state_d     = ACCUM;
        end
      end
      ACCUM: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N_INPUTS-1))
          state_d = FINAL;
      end
      FINAL: begin
        axon_d  = act;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dendrites_q <= '0;
      weights_q   <= '0;
      enabled_q   <= '0;
      idx_q       <= '0;
      axon_q      <= '0;
    end else begin
      state_q     <= state_d;
      dendrites_q <= dendrites_d;
      weights_q   <= weights_d;
      enabled_q   <= enabled_d;
      idx_q       <= idx_d;
      axon_q      <= axon_d;
    end
  end

endmodule

// File: tb/tb_neuron_seq.sv
// Directed bench for neuron_seq with N_INPUTS=4, DATA_W=16, FRAC_W=8 (either activation build).
`timescale 1ns/1ps
module tb_neuron_seq;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int FW = 8;

`ifdef NEURON_RELU_EN
  localparam logic [15:0] EXP_ALL_ONE = 16'd1024;
  localparam logic [15:0] EXP_BIG     = 16'd32767;
  localparam logic [15:0] EXP_MID     = 16'd768;
`else
  localparam logic [15:0] EXP_ALL_ONE = 16'd256;
  localparam logic [15:0] EXP_BIG     = 16'd256;
  localparam logic [15:0] EXP_MID     = 16'd256;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*DW-1:0] dendrites = '0;
  logic [(N+1)*DW-1:0] weights = '0;
  logic [N-1:0]    enabled = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   axon;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  neuron_seq #(
    .N_INPUTS (N),
    .DATA_W   (DW),
    .FRAC_W   (FW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dendrites (dendrites),
    .weights   (weights),
    .enabled   (enabled),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .axon      (axon)
  );

  function automatic logic [N*DW-1:0] pack4(input logic [15:0] v0, input logic [15:0] v1,
                                            input logic [15:0] v2, input logic [15:0] v3);
    return {v3, v2, v1, v0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Presents one vector, then scrambles the buses to show only the accepted copy matters.
  task automatic applyStimulus(input logic [N*DW-1:0] d, input logic [(N+1)*DW-1:0] w,
                               input logic [N-1:0] en);
    int edges;
    @(negedge clk);
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    dendrites = d;
    weights   = w;
    enabled   = en;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    dendrites = ~d;
    weights   = '0;
    enabled   = ~en;
    checkOutput("busy_after_accept", 32'(in_ready), 32'd0);
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput("latency", 32'(edges), 32'(N+1));
  endtask

  task automatic collectResult(input string tag, input logic [15:0] expected);
    checkOutput(tag, 32'(axon), 32'(expected));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("valid_drop", 32'(out_valid), 32'd0);
    checkOutput("ready_back", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_axon", 32'(axon), 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(pack4(16'd256, 16'd256, 16'd256, 16'd256),
                  {16'd0, pack4(16'd256, 16'd256, 16'd256, 16'd256)}, 4'b1111);
    collectResult("t1_all_ones", EXP_ALL_ONE);

    applyStimulus(pack4(16'd256, 16'd256, 16'd256, 16'd256),
                  {16'd0, pack4(16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00)}, 4'b1111);
    collectResult("t2_negative", 16'd0);

    applyStimulus(pack4(16'd256, 16'd256, 16'd256, 16'd256),
                  {16'd0, pack4(16'd0, 16'd0, 16'd0, 16'd0)}, 4'b1111);
    collectResult("t2_exact_zero", 16'd0);

    applyStimulus(pack4(16'd512, 16'd32767, 16'd32767, 16'd32767),
                  {16'hFF00, pack4(16'd256, 16'd32767, 16'd32767, 16'd32767)}, 4'b0001);
    collectResult("t3_masked", 16'd256);

    applyStimulus(pack4(16'd32767, 16'd32767, 16'd32767, 16'd32767),
                  {16'd32767, pack4(16'd32767, 16'd32767, 16'd32767, 16'd32767)}, 4'b1111);
    collectResult("t4_saturate", EXP_BIG);

    applyStimulus(pack4(16'd384, 16'd0, 16'd0, 16'd0),
                  {16'd0, pack4(16'd512, 16'd0, 16'd0, 16'd0)}, 4'b0001);
    collectResult("t_mid_value", EXP_MID);

    // -1 LSB of product floors to -1, which must not activate.
    applyStimulus(pack4(16'd1, 16'd0, 16'd0, 16'd0),
                  {16'd0, pack4(16'hFFFF, 16'd0, 16'd0, 16'd0)}, 4'b0001);
    collectResult("t_floor_neg", 16'd0);

    applyStimulus(pack4(16'd256, 16'd256, 16'd256, 16'd256),
                  {16'd0, pack4(16'd256, 16'd256, 16'd256, 16'd256)}, 4'b1111);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid  = (i == 3);
      dendrites = pack4(16'd1, 16'd2, 16'd3, 16'd4);
      @(posedge clk);
      #1;
      checkOutput("bp_axon", 32'(axon), 32'(EXP_ALL_ONE));
      checkOutput("bp_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    collectResult("t5_bp_result", EXP_ALL_ONE);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_no_ghost", 32'(out_valid), 32'd0);
    end

    @(negedge clk);
    dendrites = pack4(16'd256, 16'd256, 16'd256, 16'd256);
    weights   = {16'd0, pack4(16'd256, 16'd256, 16'd256, 16'd256)};
    enabled   = 4'b1111;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_axon", 32'(axon), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(pack4(16'd512, 16'd32767, 16'd32767, 16'd32767),
                  {16'hFF00, pack4(16'd256, 16'd32767, 16'd32767, 16'd32767)}, 4'b0001);
    collectResult("t6_after_abort", 16'd256);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/neuron_seq.md
Name: neuron_seq

Overview:
Parametrised, time-multiplexed successor to the combinational neuron. It holds one weighted-input vector plus a bias, then steps through the enabled inputs at one multiply-accumulate per clock using a single signed fixed-point multiplier. It adds the bias, applies the activation, and presents the axon value on a valid/ready output. It sits between the layer sequencer (producer) and the next layer's input buffer (consumer).

Parameters:
N_INPUTS, 32, number of dendrite inputs (>=1)
DATA_W, 16, signed two's-complement width of dendrites, weights and axon
FRAC_W, 8, fractional bits of the Q format (1.0 = 2**FRAC_W)
ACC_W, 2*DATA_W+$clog2(N_INPUTS+1), signed accumulator width; chosen so the accumulator can never overflow

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  producer has a vector ready
in_ready  out  1  block can accept a vector
dendrites  in  N_INPUTS*DATA_W  input values; slice i = dendrite i
weights  in  (N_INPUTS+1)*DATA_W  slice i = weight i; slice N_INPUTS = bias
enabled  in  N_INPUTS  per-input enable; a 0 forces that term to zero
out_valid  out  1  axon is valid
out_ready  in  1  consumer accepts the axon
axon  out  DATA_W  activated output, Q(DATA_W-FRAC_W).FRAC_W

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, axon=0, acc=0, idx=0.
- FSM states: IDLE, ACCUM, FINAL, HOLD.
- IDLE: in_ready=1. When in_valid&&in_ready:
  - register dendrites, weights and enabled;
  - set acc=0 and idx=0;
  - go to ACCUM.
- ACCUM: in_ready=0. Each cycle:
  - acc += enabled[idx] ? sext(dendrite[idx]*weight[idx]) : 0;
  - the product is full precision, 2*DATA_W bits with 2*FRAC_W fractional bits;
  - idx increments by 1;
  - when idx==N_INPUTS-1, go to FINAL.
  - Disabled inputs still take their cycle, so latency is fixed.
- FINAL:
  - sum = (acc + (sext(bias) <<< FRAC_W)) >>> FRAC_W, an arithmetic shift that truncates toward minus infinity;
  - apply the activation to sum and register the result into axon;
  - set out_valid=1 and go to HOLD.
- HOLD: out_valid=1 and axon held stable. When out_ready=1, set out_valid=0 and go to IDLE. A new vector is never accepted in the same cycle.
- Latency: out_valid rises exactly N_INPUTS+1 clock edges after the accepting edge. Minimum issue interval is N_INPUTS+3 cycles with out_ready tied high.
- Default activation is a step: axon = (sum > 0) ? (1<<FRAC_W) : 0. Exactly zero gives 0.
- Input buses are sampled only at acceptance. Changes to them while busy have no effect.
- in_valid while busy is ignored. Data is not lost, because in_ready=0 and the producer must hold.
- rst_n asserted mid-operation aborts at once: all state returns to reset values and the partial result is discarded.
- N_INPUTS=1: ACCUM lasts exactly one cycle.

Optional Feature:
- Macro: NEURON_RELU_EN.
- Defined: the activation is ReLU with saturation.
  - axon = 0 if sum <= 0;
  - axon = 2**(DATA_W-1)-1 if sum exceeds it;
  - otherwise axon = sum[DATA_W-1:0].
- Undefined: step activation as above. Latency and handshake are identical in both builds.

Decomposition:
- Package neuron_pkg holds:
  - state_t enum {IDLE, ACCUM, FINAL, HOLD};
  - function q_one(FRAC_W) returning 1<<FRAC_W;
  - function sat_to_w() for the ReLU clamp.
- One natural sub-module, neuron_mac: registered signed multiply-accumulate with clear, enable and term-enable inputs. Parametrised by DATA_W and ACC_W; instantiated once.

Test Plan:
All scenarios use N_INPUTS=4, DATA_W=16, FRAC_W=8.
1. Step build. Dendrites all 256, weights all 256, bias 0, enabled=4'b1111 -> axon=256; out_valid rises 5 edges after acceptance. ReLU build, same stimulus -> axon=1024.
2. Weights all -256, bias 0 -> axon=0 in both builds. Then weights all 0, bias 0 (sum exactly zero) -> axon=0.
3. enabled=4'b0001, dendrite0=512, weight0=256, other dendrites 32767 with weights 32767, bias=-256 -> sum=1.0. Step build gives axon=256; ReLU build gives axon=256. Confirms masked terms contribute nothing.
4. ReLU build, dendrites and weights all 32767, bias 32767 -> axon=32767 (saturated).
5. Backpressure: out_ready held 0 for 10 cycles after out_valid. Check:
   - axon is stable and in_ready=0 throughout;
   - a pulsed in_valid is not accepted;
   - after out_ready=1, out_valid drops next edge and in_ready=1.
6. Assert rst_n during ACCUM cycle 2 -> out_valid=0, axon=0, in_ready=1 immediately. A following vector completes with correct latency and value.
